// File: rtl/vec_sqrt_unit.sv
// Iterative restoring integer square root, one root bit per clock.
// Define VEC_SQRT_ROUND_EN for round-to-nearest instead of floor.
module vec_sqrt_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               InValid,
    output logic               InReady,
    input  logic [WIDTH-1:0]   Radicand,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH/2-1:0] Root,
    output logic               Busy
);

    localparam int H  = WIDTH / 2;
    localparam int RW = H + 2;
    localparam int CW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [RW-1:0]    r_rem;
    logic [H-1:0]     r_root;
    logic [CW-1:0]    r_cnt;
    logic [H-1:0]     r_out;
    logic             r_out_valid;

    logic [RW-1:0]    w_rem_sh;
    logic [RW-1:0]    w_trial;
    logic [RW-1:0]    w_rem_nxt;
    logic [H-1:0]     w_root_nxt;
    logic [H-1:0]     w_root_fin;
    logic             w_ge;
    logic             w_accept;
    logic             w_last;

    assign InReady  = (r_state == S_IDLE) & ~rst;
    assign Busy     = (r_state != S_IDLE);
    assign OutValid = r_out_valid;
    assign Root     = r_out;
    assign w_accept = InValid & InReady;
    assign w_last   = (r_cnt == '0);

    always_comb begin
        w_rem_sh   = {r_rem[RW-3:0], r_shift[WIDTH-1 -: 2]};
        w_trial    = {r_root, 2'b01};
        w_ge       = (w_rem_sh >= w_trial);
        w_rem_nxt  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
        w_root_nxt = {r_root[H-2:0], w_ge};
        w_root_fin = w_root_nxt;
`ifdef VEC_SQRT_ROUND_EN
        // Remainder above root means sqrt lies past root+0.5
        if ((w_rem_nxt > {2'b00, w_root_nxt}) && !(&w_root_nxt))
            w_root_fin = w_root_nxt + {{(H-1){1'b0}}, 1'b1};
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (OutReady) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_rem       <= '0;
            r_root      <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= Radicand;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_cnt   <= CW'(H - 1);
                    end
                end
                S_CALC: begin
                    r_shift <= {r_shift[WIDTH-3:0], 2'b00};
                    r_rem   <= w_rem_nxt;
                    r_root  <= w_root_nxt;
                    r_cnt   <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_out       <= w_root_fin;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (OutReady) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_sqrt_unit.sv
// Directed bench for vec_sqrt_unit (WIDTH=32).
module tb_vec_sqrt_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        InValid;
    logic        InReady;
    logic [31:0] Radicand;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] Root;
    logic        Busy;

    int n_vec = 0;
    int n_err = 0;

    vec_sqrt_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .Radicand (Radicand),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Root     (Root),
        .Busy     (Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input string tag, input logic [31:0] rad);
        int g = 0;
        InValid  = 1'b1;
        Radicand = rad;
        while (!InReady && g < 50) begin
            step();
            g++;
        end
        chk({tag, "_rdy"}, 32'(InReady), 32'd1);
        step();
        InValid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [15:0] exp);
        int k = 0;
        while (!OutValid && k < 40) begin
            step();
            k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'd16);
        chk({tag, "_root"}, 32'(Root), 32'(exp));
    endtask

    task automatic run_op(input string tag, input logic [31:0] rad,
                          input logic [15:0] exp);
        accept(tag, rad);
        wait_out(tag, exp);
        step();
        chk({tag, "_pulse"}, 32'(OutValid), 32'd0);
    endtask

    logic [31:0] rads [8] = '{32'd0, 32'd1, 32'd4, 32'd25,
                              32'h0001_0000, 32'd8, 32'd15,
                              32'hFFFF_FFFF};
`ifdef VEC_SQRT_ROUND_EN
    logic [15:0] exps [8] = '{16'd0, 16'd1, 16'd2, 16'd5,
                              16'h0100, 16'd3, 16'd4, 16'hFFFF};
`else
    logic [15:0] exps [8] = '{16'd0, 16'd1, 16'd2, 16'd5,
                              16'h0100, 16'd2, 16'd3, 16'hFFFF};
`endif

    initial begin
        rst      = 1'b1;
        InValid  = 1'b0;
        Radicand = '0;
        OutReady = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_inready", 32'(InReady), 32'd1);
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_root", 32'(Root), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);

        rst = 1'b1;
        step();
        chk("idle_rst_inready", 32'(InReady), 32'd0);
        chk("idle_rst_busy", 32'(Busy), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_rel_inready", 32'(InReady), 32'd1);
        chk("idle_rel_outvalid", 32'(OutValid), 32'd0);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("v%0d", i), rads[i], exps[i]);

        // Backpressure with a competing request held upstream
        OutReady = 1'b0;
        accept("bp", 32'd49);
        wait_out("bp", 16'd7);
        InValid  = 1'b1;
        Radicand = 32'd5;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", 32'(OutValid), 32'd1);
            chk("bp_root", 32'(Root), 32'd7);
            chk("bp_inready", 32'(InReady), 32'd0);
        end
        OutReady = 1'b1;
        step();
        InValid = 1'b0;
        chk("bp_rel_valid", 32'(OutValid), 32'd0);
        chk("bp_rel_busy", 32'(Busy), 32'd0);
        chk("bp_rel_inready", 32'(InReady), 32'd1);
        chk("bp_rel_root", 32'(Root), 32'd7);

        // Reset on the 8th CALC edge
        accept("mid", 32'd100);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_busy", 32'(Busy), 32'd0);
        chk("mid_valid", 32'(OutValid), 32'd0);
        chk("mid_root", 32'(Root), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (OutValid) seen++;
            end
            chk("mid_no_result", 32'(seen), 32'd0);
        end
        run_op("post", 32'd9, 16'd3);

        // Back-to-back with InValid held high
        accept("b2b_a", 32'd144);
        InValid  = 1'b1;
        Radicand = 32'd169;
        wait_out("b2b_a", 16'd12);
        step();
        chk("b2b_idle_ready", 32'(InReady), 32'd1);
        chk("b2b_a_pulse", 32'(OutValid), 32'd0);
        step();
        InValid = 1'b0;
        chk("b2b_b_busy", 32'(Busy), 32'd1);
        wait_out("b2b_b", 16'd13);
        step();
        chk("b2b_b_pulse", 32'(OutValid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
